// File: rtl/hilo_muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: funct codes, FSM states
// and small sign helpers.
package hilo_muldiv_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [5:0]        funct_t;

    localparam funct_t FN_MTHI  = 6'h11;
    localparam funct_t FN_MTLO  = 6'h13;
    localparam funct_t FN_MULT  = 6'h18;
    localparam funct_t FN_MULTU = 6'h19;
    localparam funct_t FN_DIV   = 6'h1A;
    localparam funct_t FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} muldiv_state_t;

    // Magnitude of an operand; unsigned ops pass the raw bits through.
    function automatic word_t abs_if(input word_t v, input logic signed_op);
        return (signed_op && v[WORD_W-1]) ? -v : v;
    endfunction

    function automatic word_t neg_if(input word_t v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// 32-step restoring divider on unsigned magnitudes; one quotient bit per step.
module seq_divider
    import hilo_muldiv_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clear,
    input  logic  start,
    input  logic  step,
    input  word_t dividend,
    input  word_t divisor,
    output word_t quotient,
    output word_t remainder,
    output logic  last
);

    word_t       rem_q;
    word_t       quo_q;
    word_t       dsr_q;
    logic [4:0]  cnt;
    logic [32:0] partial;
    logic        fits;
    word_t       rem_sub;

    // Remainder stays below the divisor, so the shifted partial fits in 33 bits
    // and the difference always fits back into 32.
    always_comb begin
        partial = {rem_q, quo_q[WORD_W-1]};
        fits    = (partial >= {1'b0, dsr_q});
        rem_sub = partial[WORD_W-1:0] - dsr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt   <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
            cnt   <= 5'd31;
        end else if (step) begin
            if (fits) begin
                rem_q <= rem_sub;
                quo_q <= {quo_q[WORD_W-2:0], 1'b1};
            end else begin
                rem_q <= partial[WORD_W-1:0];
                quo_q <= {quo_q[WORD_W-2:0], 1'b0};
            end
            if (cnt != 5'd0)
                cnt <= cnt - 5'd1;
        end
    end

    assign last      = (cnt == 5'd0);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO owner for Execute: multi-cycle MULT/DIV (signed and unsigned) plus MTHI/MTLO.
//   state | meaning
//   IDLE  | ready for a request; MTHI/MTLO complete here
//   MUL   | 32 shift-add iterations
//   DIV   | 32 restoring-divide iterations in seq_divider
//   FIX   | sign correction, HI/LO write, done pulse (divide by zero: no write)
module hilo_muldiv
    import hilo_muldiv_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   req_valid,
    output logic   req_ready,
    input  funct_t req_op,
    input  word_t  req_a,
    input  word_t  req_b,
    output logic   busy,
    output logic   done,
    output word_t  hi,
    output word_t  lo
);

    muldiv_state_t state, state_nxt;

    logic        accept;
    logic        is_mul;
    logic        is_div;
    logic        signed_op;
    word_t       a_mag;
    word_t       b_mag;

    logic [63:0] mul_acc;
    logic [63:0] mul_mcand;
    word_t       mul_mplier;
    logic [4:0]  mul_cnt;
    logic        neg_res;
    logic        neg_rem;
    logic        op_div;
    logic        div_zero;

    logic        div_start;
    logic        div_step;
    logic        div_last;
    word_t       div_quo;
    word_t       div_rem;
    logic [63:0] mul_fixed;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready && !flush;
    assign is_mul    = (req_op == FN_MULT) || (req_op == FN_MULTU);
    assign is_div    = (req_op == FN_DIV)  || (req_op == FN_DIVU);
    assign signed_op = (req_op == FN_MULT) || (req_op == FN_DIV);
    assign a_mag     = abs_if(req_a, signed_op);
    assign b_mag     = abs_if(req_b, signed_op);
    assign mul_fixed = neg_res ? -mul_acc : mul_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        div_step  = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_mul) begin
                        state_nxt = MUL;
                    end else if (accept && is_div) begin
                        if (req_b == '0) begin
                            state_nxt = FIX;
                        end else begin
                            state_nxt = DIV;
                            div_start = 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (mul_cnt == 5'd0)
                        state_nxt = FIX;
                end
                DIV: begin
                    div_step = 1'b1;
                    if (div_last)
                        state_nxt = FIX;
                end
                FIX:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    seq_divider u_div (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .start     (div_start),
        .step      (div_step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (div_quo),
        .remainder (div_rem),
        .last      (div_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi         <= '0;
            lo         <= '0;
            done       <= 1'b0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            op_div     <= 1'b0;
            div_zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                mul_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            if (req_op == FN_MTHI)
                                hi <= req_a;
                            if (req_op == FN_MTLO)
                                lo <= req_a;
                            if (is_mul || is_div) begin
                                neg_res  <= signed_op && (req_a[WORD_W-1] ^ req_b[WORD_W-1]);
                                neg_rem  <= signed_op && req_a[WORD_W-1];
                                op_div   <= is_div;
                                div_zero <= is_div && (req_b == '0);
                            end
                            if (is_mul) begin
                                mul_acc    <= '0;
                                mul_mcand  <= {32'b0, a_mag};
                                mul_mplier <= b_mag;
                                mul_cnt    <= 5'd31;
                            end
                        end
                    end
                    MUL: begin
                        if (mul_mplier[0])
                            mul_acc <= mul_acc + mul_mcand;
                        mul_mcand  <= {mul_mcand[62:0], 1'b0};
                        mul_mplier <= {1'b0, mul_mplier[WORD_W-1:1]};
                        if (mul_cnt != 5'd0)
                            mul_cnt <= mul_cnt - 5'd1;
                    end
                    FIX: begin
                        done <= 1'b1;
                        if (op_div) begin
                            if (!div_zero) begin
                                lo <= neg_if(div_quo, neg_res);
                                hi <= neg_if(div_rem, neg_rem);
                            end
                        end else begin
                            hi <= mul_fixed[63:32];
                            lo <= mul_fixed[31:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: directed cases plus random ops against an
// arithmetic reference model; a monitor checks every done pulse.
module tb_hilo_muldiv;
    import hilo_muldiv_pkg::*;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    logic   flush = 1'b0;
    logic   req_valid = 1'b0;
    funct_t req_op = FN_MTHI;
    word_t  req_a = '0;
    word_t  req_b = '0;
    logic   req_ready, busy, done;
    word_t  hi, lo;

    typedef struct {
        word_t hi;
        word_t lo;
        int    due;
    } exp_t;

    exp_t  sb_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    word_t m_hi = '0;
    word_t m_lo = '0;

    hilo_muldiv dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                e = sb_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.due));
                check("result_hi", 64'(hi), 64'(e.hi));
                check("result_lo", 64'(lo), 64'(e.lo));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: req_ready=0 after %0d cycles, expected 1", n);
        end
    endtask

    // Called at a negedge with the unit ready; the accept happens on the next edge.
    task automatic issue(input funct_t op, input word_t a, input word_t b, input bit track);
        longint sa, sb, q, r, p;
        logic [63:0] pu;
        word_t nh, nl;
        int lat;
        bit muldiv;
        int e_edge;
        sa = $signed(a);
        sb = $signed(b);
        nh = m_hi;
        nl = m_lo;
        lat = 33;
        muldiv = 1'b1;
        case (op)
            FN_MULT: begin
                p = sa * sb;
                nh = p[63:32];
                nl = p[31:0];
            end
            FN_MULTU: begin
                pu = {32'b0, a} * {32'b0, b};
                nh = pu[63:32];
                nl = pu[31:0];
            end
            FN_DIV: begin
                if (b == 0) lat = 1;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    nl = q[31:0];
                    nh = r[31:0];
                end
            end
            FN_DIVU: begin
                if (b == 0) lat = 1;
                else begin
                    nl = a / b;
                    nh = a % b;
                end
            end
            default: muldiv = 1'b0;
        endcase
        req_op = op;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        e_edge = cyc + 1;
        if (muldiv && track) begin
            sb_q.push_back('{hi: nh, lo: nl, due: e_edge + lat});
            m_hi = nh;
            m_lo = nl;
        end
        if (op == FN_MTHI) m_hi = a;
        if (op == FN_MTLO) m_lo = a;
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (!muldiv) begin
            @(negedge clk);
            check("mt_hi", 64'(hi), 64'(m_hi));
            check("mt_lo", 64'(lo), 64'(m_lo));
            check("mt_busy", 64'(busy), 64'(0));
        end
    endtask

    task automatic run(input funct_t op, input word_t a, input word_t b);
        wait_ready();
        issue(op, a, b, 1'b1);
    endtask

    initial begin
        funct_t ops[8];
        ops[0] = FN_MULT; ops[1] = FN_MULTU; ops[2] = FN_DIV;  ops[3] = FN_DIVU;
        ops[4] = FN_MTHI; ops[5] = FN_MTLO;  ops[6] = 6'h00;   ops[7] = 6'h2A;

        repeat (2) @(negedge clk);
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        reset = 1'b0;

        run(FN_MTHI, 32'h12345678, 32'h0);
        run(FN_MTLO, 32'h9ABCDEF0, 32'h0);
        run(FN_MULT, 32'hFFFFFFFE, 32'd3);
        run(FN_MULTU, 32'hFFFFFFFE, 32'd3);
        run(FN_DIV, 32'hFFFFFFF9, 32'd2);
        run(FN_DIVU, 32'd7, 32'd2);
        run(FN_MTHI, 32'hAAAA0000, 32'h0);
        run(FN_MTLO, 32'h00005555, 32'h0);
        run(FN_DIV, 32'h1234, 32'h0);
        run(FN_DIV, 32'h80000000, 32'hFFFFFFFF);
        run(FN_MULT, 32'h80000000, 32'h80000000);
        @(negedge clk);
        check("mid_busy", 64'(busy), 64'(1));
        check("mid_ready", 64'(req_ready), 64'(0));

        // Flush ten cycles into a MULT, then hold requests against flush.
        wait_ready();
        issue(FN_MULT, 32'd5, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_ready", 64'(req_ready), 64'(1));
        check("flush_hi", 64'(hi), 64'(m_hi));
        check("flush_lo", 64'(lo), 64'(m_lo));
        @(negedge clk);
        req_valid = 1'b1;
        req_op = FN_MTHI;
        req_a = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        req_op = FN_MULT;
        req_b = 32'd9;
        repeat (2) @(negedge clk);
        check("flushreq_hi", 64'(hi), 64'(m_hi));
        check("flushreq_busy", 64'(busy), 64'(0));
        req_valid = 1'b0;
        flush = 1'b0;

        // Back-to-back: DIVU issued in the done cycle of a MULTU.
        run(FN_MULTU, 32'h00012345, 32'h00067890);
        wait_ready();
        check("b2b_done", 64'(done), 64'(1));
        issue(FN_DIVU, 32'd1000, 32'd7, 1'b1);
        @(negedge clk);
        check("b2b_accepted", 64'(busy), 64'(1));

        // Asynchronous reset in the middle of a DIV.
        wait_ready();
        issue(FN_DIV, 32'd100, 32'd3, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_hi", 64'(hi), 64'(0));
        check("arst_lo", 64'(lo), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_ready", 64'(req_ready), 64'(1));
        check("arst_done", 64'(done), 64'(0));
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 40; i++) begin
            int k;
            word_t a, b;
            k = $urandom_range(0, 7);
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h80000000;
            run(ops[k], a, b);
        end

        wait_ready();
        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
